// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core with on-the-fly key expansion, UNROLL rounds per clock.
// Latency: out_valid rises 10/UNROLL clocks after the accepting edge; one block in flight.
// Backpressure: ciphertext is held with out_valid high until out_ready; in_ready stays low meanwhile.
module aes_encrypt_iter #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5)) begin : g_bad_unroll
    $error("aes_encrypt_iter: UNROLL must be 1, 2 or 5");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Byte b = 4*col + row lives at bits [127-8b -: 8]; a column is one 32-bit word, row 0 in the MSBs.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int b = 0; b < 16; b++) res[8*b +: 8] = SBOX[s[8*b +: 8]];
    return res;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) res[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return res;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Round constant for rounds 1..10; any other index yields zero and is never used in RUN.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One step of the key schedule: previous round key in, next round key out.
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  fsm_t         fsm, fsm_nxt;
  logic [127:0] st, rk, ct_q;
  logic [127:0] st_nxt, rk_nxt;
  logic [3:0]   rnd, r_i;
  logic         armed;
  logic         last;
  logic         accept;

  assign accept     = in_valid && in_ready;
  assign ciphertext = ct_q;

  // Combinational chain of UNROLL rounds starting at round rnd.
  always_comb begin
    st_nxt = st;
    rk_nxt = rk;
    r_i    = rnd;
    for (int i = 0; i < UNROLL; i++) begin
      r_i    = rnd + 4'(i);
      rk_nxt = key_step(rk_nxt, rcon_of(r_i));
      if (r_i == 4'd10) st_nxt = shift_rows(sub_bytes(st_nxt)) ^ rk_nxt;
      else              st_nxt = mix_columns(shift_rows(sub_bytes(st_nxt))) ^ rk_nxt;
    end
    last = (rnd + 4'(UNROLL - 1)) == 4'd10;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_nxt;
  end

  // Next state and handshake outputs; in_ready is held off until the first clock after reset.
  always_comb begin
    fsm_nxt   = fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = armed;
        if (in_valid && armed) fsm_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) fsm_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  // Datapath registers: load on acceptance, iterate in RUN, capture ciphertext on the final round.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= '0;
      rk    <= '0;
      rnd   <= '0;
      ct_q  <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (fsm)
        IDLE: begin
          if (accept) begin
            st  <= plaintext ^ key;
            rk  <= key;
            rnd <= 4'd1;
          end
        end
        RUN: begin
          st <= st_nxt;
          rk <= rk_nxt;
          if (last) begin
            ct_q <= st_nxt;
            rnd  <= 4'd0;
          end else begin
            rnd <= rnd + 4'(UNROLL);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: three instances (UNROLL 1, 2, 5) against a byte-matrix AES reference.
// Directed FIPS vectors, backpressure, back-to-back, reset abort, then random blocks.
module tb_aes_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] pt, ky;
  logic [2:0]   iv, ordy;
  wire  [2:0]   ir, ov, bz;
  wire  [127:0] ct0, ct1, ct2;
  int           total = 0;
  int           bad = 0;
  logic [7:0]   sb [256];

  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  always #5 clk = ~clk;

  aes_encrypt_iter #(.UNROLL(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .plaintext(pt), .key(ky), .out_valid(ov[0]), .out_ready(ordy[0]), .ciphertext(ct0), .busy(bz[0]));
  aes_encrypt_iter #(.UNROLL(2)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .plaintext(pt), .key(ky), .out_valid(ov[1]), .out_ready(ordy[1]), .ciphertext(ct1), .busy(bz[1]));
  aes_encrypt_iter #(.UNROLL(5)) u5 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .plaintext(pt), .key(ky), .out_valid(ov[2]), .out_ready(ordy[2]), .ciphertext(ct2), .busy(bz[2]));

  function automatic logic [127:0] ct_of(input int k);
    case (k)
      0:       return ct0;
      1:       return ct1;
      default: return ct2;
    endcase
  endfunction

  function automatic int ur(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      default: return 5;
    endcase
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] mcoef(input int d);
    case (d)
      0:       return 8'h02;
      1:       return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] kk, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [7:0]   a [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   rc, acc;
    logic [31:0]  tw;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = kk[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {sb[tw[31:24]], sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        a[r][c] = p[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rn = 1; rn <= 10; rn++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb[a[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rn < 10) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(mcoef((j - r + 4) % 4), t[j][c]);
          end else begin
            acc = t[r][c];
          end
          a[r][c] = acc ^ w[4*rn+c][31-8*r -: 8];
        end
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = a[r][c];
    return res;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one block on instance k, check latency/result/handshake, optionally stall the sink.
  task automatic send(input int k, input logic [127:0] kk, input logic [127:0] p,
                      input bit early, input int hold, output logic [127:0] got);
    int n;
    logic [127:0] expv;
    expv = aes_ref(kk, p);
    n = 0;
    while (!ir[k] && n < 40) begin tick(); n++; end
    chk("ready_before_send", 128'(ir[k]), 128'(1));
    ky = kk; pt = p; iv[k] = 1'b1; ordy[k] = early;
    tick();
    iv[k] = 1'b0;
    ky = {$urandom, $urandom, $urandom, $urandom};
    pt = {$urandom, $urandom, $urandom, $urandom};
    chk("busy_after_accept", 128'(bz[k]), 128'(1));
    n = 0;
    while (!ov[k] && n < 40) begin tick(); n++; end
    chk("latency", 128'(n), 128'(10 / ur(k)));
    got = ct_of(k);
    chk("ciphertext_vs_model", got, expv);
    chk("in_ready_low_done", 128'(ir[k]), 128'(0));
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("hold_valid", 128'(ov[k]), 128'(1));
        chk("hold_ct_stable", ct_of(k), got);
        chk("hold_in_ready_low", 128'(ir[k]), 128'(0));
      end
    end
    ordy[k] = 1'b1;
    tick();
    ordy[k] = 1'b0;
    chk("valid_drops", 128'(ov[k]), 128'(0));
    chk("busy_clears", 128'(bz[k]), 128'(0));
    chk("ready_returns", 128'(ir[k]), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [127:0] got;
    logic [127:0] got_q [2];
    int           tout [2];
    int           acc, outs, cyc, seen;
    logic         rdy_b;
    logic [7:0]   inv;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end

    // Reset with in_valid held high on all instances: nothing may be accepted.
    rst_n = 1'b0; iv = 3'b111; ordy = 3'b000; pt = PC; ky = KC;
    repeat (3) tick();
    chk("rst_in_ready", 128'(ir), 128'(0));
    chk("rst_out_valid", 128'(ov), 128'(0));
    chk("rst_busy", 128'(bz), 128'(0));
    chk("rst_ct", ct0, 128'h0);
    rst_n = 1'b1; iv = 3'b000;
    chk("release_in_ready_low", 128'(ir), 128'(0));
    tick();
    chk("first_clock_ready", 128'(ir), 128'(7));
    chk("no_accept_in_reset", 128'(bz), 128'(0));

    // Known-answer vectors.
    send(0, KB, PB, 1'b0, 0, got);
    chk("fips_b", got, CB);
    send(0, KC, PC, 1'b0, 0, got);
    chk("fips_c1_u1", got, CC);
    send(1, KC, PC, 1'b0, 0, got);
    chk("fips_c1_u2", got, CC);
    send(2, KC, PC, 1'b0, 0, got);
    chk("fips_c1_u5", got, CC);
    send(0, 128'h0, 128'h0, 1'b0, 0, got);
    chk("all_zero", got, CZ);

    // Backpressure for 20 cycles, then early out_ready has no effect on latency.
    send(0, KC, PC, 1'b0, 20, got);
    chk("bp_result", got, CC);
    send(0, KB, PB, 1'b1, 0, got);
    chk("early_ready_result", got, CB);

    // Back-to-back: C.1 then B with in_valid held, inputs switched during RUN.
    acc = 0; outs = 0; cyc = 0;
    tout[0] = 0; tout[1] = 0; got_q[0] = '0; got_q[1] = '0;
    ky = KC; pt = PC; iv[0] = 1'b1; ordy[0] = 1'b1;
    while (outs < 2 && cyc < 80) begin
      rdy_b = ir[0];
      tick();
      cyc++;
      if (rdy_b && iv[0]) begin
        acc++;
        if (acc == 1) begin ky = KB; pt = PB; end
        else iv[0] = 1'b0;
      end
      if (ov[0]) begin
        tout[outs] = cyc;
        got_q[outs] = ct0;
        outs++;
      end
    end
    iv[0] = 1'b0;
    tick();
    ordy[0] = 1'b0;
    chk("b2b_count", 128'(outs), 128'(2));
    chk("b2b_first", got_q[0], CC);
    chk("b2b_second", got_q[1], CB);
    chk("b2b_period", 128'(tout[1] - tout[0]), 128'(12));

    // Reset at round 5 aborts the block.
    ky = KC; pt = PC; iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    repeat (4) tick();
    chk("mid_run_busy", 128'(bz[0]), 128'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 128'(bz[0]), 128'(0));
    chk("abort_ready_low", 128'(ir[0]), 128'(0));
    seen = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (ov[0]) seen++; end
    chk("abort_no_valid", 128'(seen), 128'(0));
    chk("abort_ready", 128'(ir[0]), 128'(1));
    send(0, KC, PC, 1'b0, 0, got);
    chk("after_abort_c1", got, CC);

    // in_valid in the same edge as reset while idle and ready: reset wins.
    iv[0] = 1'b1; rst_n = 1'b0;
    tick();
    iv[0] = 1'b0; rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (ov[0] || bz[0]) seen++; end
    chk("reset_beats_accept", 128'(seen), 128'(0));

    // Random blocks on every instance against the model.
    for (int i = 0; i < 12; i++)
      send(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
           1'($urandom_range(0, 1)), $urandom_range(0, 3), got);
    for (int k = 1; k < 3; k++)
      for (int i = 0; i < 4; i++)
        send(k, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             1'($urandom_range(0, 1)), $urandom_range(0, 3), got);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
